// File: rtl/pipe_stage_ctrl.sv
// Pipeline sequencer: PC write enable, per-register load enables and valid tracking for NREG
// pipeline registers. Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_stage_ctrl #(
  parameter int unsigned NREG     = 2,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              imem_ready,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  input  logic              load_use,
  input  logic              flush,
  output logic              pc_we,
  output logic [NREG-1:0]   stage_ena,
  output logic [NREG-1:0]   stage_valid,
  output logic              stall,
  output logic [WAIT_W-1:0] wait_cnt,
  output logic              mem_timeout,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_retired
);

  logic [NREG-1:0]   valid_q, valid_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic              mem_wait;
  logic              wait_expired;

  // A data access only blocks when the final register actually holds an instruction.
  assign mem_wait     = dmem_req & ~dmem_ready & valid_q[NREG-1];
  assign wait_expired = (wait_q == WAIT_W'(MAX_WAIT));

  always_comb begin
    pc_we     = 1'b0;
    stage_ena = '0;
    stall     = 1'b0;
    valid_d   = valid_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    if (reset && ena) begin
      if (mem_wait && !wait_expired) begin
        stall  = 1'b1;
        wait_d = wait_q + WAIT_W'(1);
      end else begin
        wait_d    = '0;
        stage_ena = '1;
        for (int unsigned k = 1; k < NREG; k++) begin
          valid_d[k] = valid_q[k-1];
        end
        if (mem_wait) begin
          // Forced release after an over-long wait: plain advance, flag sticks.
          timeout_d  = 1'b1;
          pc_we      = 1'b1;
          valid_d[0] = 1'b1;
        end else if (flush) begin
          pc_we      = 1'b1;
          valid_d[0] = 1'b0;
        end else if (load_use) begin
          stage_ena[0] = 1'b0;
          valid_d[0]   = valid_q[0];
          valid_d[1]   = 1'b0;
          stall        = 1'b1;
        end else if (!imem_ready) begin
          valid_d[0] = 1'b0;
          stall      = 1'b1;
        end else begin
          pc_we      = 1'b1;
          valid_d[0] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q   <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign stage_valid = valid_q;
  assign wait_cnt    = wait_q;
  assign mem_timeout = timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] retired_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      retired_q   <= '0;
    end else begin
      if (stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (stage_ena[NREG-1] && valid_q[NREG-1]) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_retired      = retired_q;
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_retired      = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl: directed vector table, perf sequence and randomized
// run against an action-level reference model.
module tb_pipe_stage_ctrl;

  localparam int unsigned NREG     = 2;
  localparam int unsigned MAX_WAIT = 3;
  localparam int unsigned WAIT_W   = 8;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, ena, imem_ready, dmem_req, dmem_ready, load_use, flush;
  logic              pc_we, stall, mem_timeout;
  logic [NREG-1:0]   stage_ena, stage_valid;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       perf_stall_cycles, perf_retired;

  pipe_stage_ctrl #(.NREG(NREG), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
    .clk(clk), .reset(reset), .ena(ena), .imem_ready(imem_ready), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .load_use(load_use), .flush(flush), .pc_we(pc_we),
    .stage_ena(stage_ena), .stage_valid(stage_valid), .stall(stall), .wait_cnt(wait_cnt),
    .mem_timeout(mem_timeout), .perf_stall_cycles(perf_stall_cycles),
    .perf_retired(perf_retired)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pipeline contents as a list of occupancy bits, one action per cycle.
  typedef enum {ActReset, ActFreeze, ActWait, ActRelease, ActFlush, ActBubble, ActFetchMiss,
                ActAdvance} act_e;

  bit          mv[NREG];
  bit          nv[NREG];
  int unsigned mwait = 0, nwait;
  bit          mto = 1'b0, nto;
  bit [31:0]   mstall = 0, mret = 0, nstall, nret;
  bit          e_pc, e_stall;
  bit [NREG-1:0] e_se;

  task automatic model_eval();
    act_e a;
    bit   tok;
    if (!reset)                                      a = ActReset;
    else if (!ena)                                   a = ActFreeze;
    else if (dmem_req && !dmem_ready && mv[NREG-1])  a = (mwait < MAX_WAIT) ? ActWait : ActRelease;
    else if (flush)                                  a = ActFlush;
    else if (load_use)                               a = ActBubble;
    else if (!imem_ready)                            a = ActFetchMiss;
    else                                             a = ActAdvance;

    e_pc    = a inside {ActRelease, ActFlush, ActAdvance};
    e_stall = a inside {ActWait, ActBubble, ActFetchMiss};
    if (a inside {ActRelease, ActFlush, ActFetchMiss, ActAdvance}) e_se = '1;
    else if (a == ActBubble) e_se = {{(NREG-1){1'b1}}, 1'b0};
    else e_se = '0;

    nv    = mv;
    nwait = (a == ActFreeze) ? mwait : (a == ActWait) ? mwait + 1 : 0;
    nto   = (a == ActReset) ? 1'b0 : (a == ActRelease) ? 1'b1 : mto;
    if (a == ActReset) begin
      foreach (nv[k]) nv[k] = 1'b0;
    end else if (a == ActBubble) begin
      for (int k = NREG - 1; k >= 2; k--) nv[k] = mv[k-1];
      nv[1] = 1'b0;
    end else if (e_se[0]) begin
      tok = (a == ActRelease) || (a == ActAdvance);
      for (int k = NREG - 1; k >= 1; k--) nv[k] = mv[k-1];
      nv[0] = tok;
    end
    if (a == ActReset) begin
      nstall = 0;
      nret   = 0;
    end else begin
      nstall = mstall + (e_stall ? 32'd1 : 32'd0);
      nret   = mret + ((e_se[NREG-1] && mv[NREG-1]) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic model_check();
    logic [NREG-1:0] pv;
    foreach (mv[k]) pv[k] = mv[k];
    chk("pc_we", 64'(pc_we), 64'(e_pc));
    chk("stage_ena", 64'(stage_ena), 64'(e_se));
    chk("stall", 64'(stall), 64'(e_stall));
    chk("stage_valid", 64'(stage_valid), 64'(pv));
    chk("wait_cnt", 64'(wait_cnt), 64'(mwait));
    chk("mem_timeout", 64'(mem_timeout), 64'(mto));
    chk("perf_stall_cycles", 64'(perf_stall_cycles), PerfOn ? 64'(mstall) : 64'd0);
    chk("perf_retired", 64'(perf_retired), PerfOn ? 64'(mret) : 64'd0);
  endtask

  task automatic begin_cycle(input bit r, e, i, dq, dr, l, f, input bit do_check);
    @(negedge clk);
    reset = r; ena = e; imem_ready = i; dmem_req = dq; dmem_ready = dr; load_use = l; flush = f;
    #1;
    model_eval();
    if (do_check) model_check();
  endtask

  task automatic end_cycle();
    @(posedge clk);
    mv = nv; mwait = nwait; mto = nto; mstall = nstall; mret = nret;
  endtask

  typedef struct {
    bit rst, en, imr, dreq, drdy, lu, fl;
    bit pc; bit [1:0] se; bit st; bit [1:0] vl; int unsigned wt; bit to;
  } vec_t;

  function automatic vec_t v(bit rst, en, imr, dreq, drdy, lu, fl,
                             bit pc, bit [1:0] se, bit st, bit [1:0] vl, int unsigned wt, bit to);
    vec_t r;
    r.rst = rst; r.en = en; r.imr = imr; r.dreq = dreq; r.drdy = drdy; r.lu = lu; r.fl = fl;
    r.pc = pc; r.se = se; r.st = st; r.vl = vl; r.wt = wt; r.to = to;
    return r;
  endfunction

  vec_t tbl[27];

  initial begin
    reset = 1'b0; ena = 1'b0; imem_ready = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    load_use = 1'b0; flush = 1'b0;
    foreach (mv[k]) mv[k] = 1'b0;

    //            rst en imr dq dr lu fl   pc  se     st  valid  wt to
    tbl[0]  = v(0, 1, 1, 0, 0, 0, 0,   0, 2'b00, 0, 2'b00, 0, 0);
    tbl[1]  = v(1, 1, 1, 0, 0, 0, 0,   1, 2'b11, 0, 2'b00, 0, 0);
    tbl[2]  = v(1, 1, 1, 0, 0, 0, 0,   1, 2'b11, 0, 2'b01, 0, 0);
    tbl[3]  = v(1, 1, 1, 0, 0, 0, 0,   1, 2'b11, 0, 2'b11, 0, 0);
    tbl[4]  = v(1, 1, 1, 1, 0, 0, 0,   0, 2'b00, 1, 2'b11, 0, 0);
    tbl[5]  = v(1, 1, 1, 1, 0, 0, 0,   0, 2'b00, 1, 2'b11, 1, 0);
    tbl[6]  = v(1, 1, 1, 1, 0, 0, 0,   0, 2'b00, 1, 2'b11, 2, 0);
    tbl[7]  = v(1, 1, 1, 1, 1, 0, 0,   1, 2'b11, 0, 2'b11, 3, 0);
    tbl[8]  = v(1, 1, 1, 0, 0, 0, 0,   1, 2'b11, 0, 2'b11, 0, 0);
    tbl[9]  = v(1, 1, 1, 1, 0, 0, 0,   0, 2'b00, 1, 2'b11, 0, 0);
    tbl[10] = v(1, 1, 1, 1, 0, 0, 0,   0, 2'b00, 1, 2'b11, 1, 0);
    tbl[11] = v(1, 1, 1, 1, 0, 0, 0,   0, 2'b00, 1, 2'b11, 2, 0);
    tbl[12] = v(1, 1, 1, 1, 0, 0, 0,   1, 2'b11, 0, 2'b11, 3, 0);
    tbl[13] = v(1, 1, 1, 0, 0, 0, 0,   1, 2'b11, 0, 2'b11, 0, 1);
    tbl[14] = v(1, 1, 1, 0, 0, 1, 0,   0, 2'b10, 1, 2'b11, 0, 1);
    tbl[15] = v(1, 1, 1, 0, 0, 0, 0,   1, 2'b11, 0, 2'b01, 0, 1);
    tbl[16] = v(1, 1, 0, 0, 0, 0, 1,   1, 2'b11, 0, 2'b11, 0, 1);
    tbl[17] = v(1, 1, 0, 0, 0, 0, 0,   0, 2'b11, 1, 2'b10, 0, 1);
    tbl[18] = v(1, 1, 1, 0, 0, 0, 0,   1, 2'b11, 0, 2'b00, 0, 1);
    tbl[19] = v(1, 0, 1, 0, 0, 0, 0,   0, 2'b00, 0, 2'b01, 0, 1);
    tbl[20] = v(1, 0, 1, 1, 0, 0, 0,   0, 2'b00, 0, 2'b01, 0, 1);
    tbl[21] = v(1, 1, 1, 0, 0, 0, 0,   1, 2'b11, 0, 2'b01, 0, 1);
    tbl[22] = v(1, 1, 0, 0, 0, 1, 0,   0, 2'b10, 1, 2'b11, 0, 1);
    tbl[23] = v(1, 1, 1, 1, 0, 0, 0,   1, 2'b11, 0, 2'b01, 0, 1);
    tbl[24] = v(1, 1, 1, 1, 0, 0, 0,   0, 2'b00, 1, 2'b11, 0, 1);
    tbl[25] = v(0, 1, 1, 1, 0, 0, 0,   0, 2'b00, 0, 2'b11, 1, 1);
    tbl[26] = v(1, 1, 1, 0, 0, 0, 0,   1, 2'b11, 0, 2'b00, 0, 0);

    // Two reset edges establish a known state before anything is compared.
    begin_cycle(0, 0, 0, 0, 0, 0, 0, 1'b0); end_cycle();
    begin_cycle(0, 0, 0, 0, 0, 0, 0, 1'b0); end_cycle();

    for (int n = 0; n < 27; n++) begin
      begin_cycle(tbl[n].rst, tbl[n].en, tbl[n].imr, tbl[n].dreq, tbl[n].drdy, tbl[n].lu,
                  tbl[n].fl, 1'b1);
      chk($sformatf("vec%0d.pc_we", n), 64'(pc_we), 64'(tbl[n].pc));
      chk($sformatf("vec%0d.stage_ena", n), 64'(stage_ena), 64'(tbl[n].se));
      chk($sformatf("vec%0d.stall", n), 64'(stall), 64'(tbl[n].st));
      chk($sformatf("vec%0d.stage_valid", n), 64'(stage_valid), 64'(tbl[n].vl));
      chk($sformatf("vec%0d.wait_cnt", n), 64'(wait_cnt), 64'(tbl[n].wt));
      chk($sformatf("vec%0d.mem_timeout", n), 64'(mem_timeout), 64'(tbl[n].to));
      end_cycle();
    end

    // Perf: reset, fill, 5 retiring cycles, 2 dmem stall cycles.
    begin_cycle(0, 1, 1, 0, 0, 0, 0, 1'b1); end_cycle();
    for (int n = 0; n < 7; n++) begin
      begin_cycle(1, 1, 1, 0, 0, 0, 0, 1'b1); end_cycle();
    end
    for (int n = 0; n < 2; n++) begin
      begin_cycle(1, 1, 1, 1, 0, 0, 0, 1'b1); end_cycle();
    end
    begin_cycle(1, 0, 1, 0, 0, 0, 0, 1'b1);
    chk("perf.retired", 64'(perf_retired), PerfOn ? 64'd5 : 64'd0);
    chk("perf.stall_cycles", 64'(perf_stall_cycles), PerfOn ? 64'd2 : 64'd0);
    end_cycle();

    for (int n = 0; n < 3000; n++) begin
      begin_cycle($urandom_range(63) != 0, $urandom_range(7) != 0, $urandom_range(3) != 0,
                  1'($urandom_range(1)), 1'($urandom_range(2) == 0),
                  $urandom_range(7) == 0, $urandom_range(7) == 0, 1'b1);
      end_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_ctrl.md
Name: pipe_stage_ctrl

Overview:
Parametrised pipeline sequencer for the Strontium core family. It is the next generation of the fixed two-register enable controller and drives the PC write enable plus one enable per pipeline register (IF_ID, ID_EXE, ...) for NREG registers. It tracks per-register valid bits and resolves stalls from instruction and data memory wait states and from load-use hazards. It inserts bubbles, honours flushes and enforces a bounded data-memory wait with a timeout.

Parameters:
NREG, 2, number of pipeline registers after the PC (register 0 = IF_ID), 2..8
MAX_WAIT, 15, max consecutive dmem wait cycles before forced release, 1..255
WAIT_W, 8, width of wait_cnt, must hold MAX_WAIT

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  synchronous, active-low; reset==0 at a rising edge resets all state
ena  in  1  global CPU enable; 0 freezes the pipeline
imem_ready  in  1  instruction word at IMEM_raddr valid this cycle
dmem_req  in  1  instruction in final register is accessing DMEM this cycle
dmem_ready  in  1  DMEM access completes this cycle
load_use  in  1  ID needs the GPR destination of a load still in EXE
flush  in  1  discard instruction in register 0 (redirect)
pc_we  out  1  PC register write enable
stage_ena  out  NREG  per-register load enable
stage_valid  out  NREG  registered valid bit per pipeline register
stall  out  1  high in any cycle where pc_we==0 while ena==1
wait_cnt  out  WAIT_W  consecutive dmem wait cycles so far
mem_timeout  out  1  sticky: a dmem wait reached MAX_WAIT
perf_stall_cycles  out  32  stall cycle count (feature-gated)
perf_retired  out  32  valid instructions leaving the last register (feature-gated)

Behaviour:
- Reset values: stage_valid=0, wait_cnt=0, mem_timeout=0, perf counters=0. While reset==0, pc_we, stage_ena and stall are forced to 0 combinationally.
- pc_we, stage_ena and stall are combinational from inputs and state. stage_valid updates on the clock edge. Latency is 0 cycles from inputs to enables.
- Decision priority per cycle, highest first:
  1. ena==0: all enables 0, stall 0, state held; wait_cnt holds.
  2. mem_wait = dmem_req & ~dmem_ready & stage_valid[NREG-1]:
     - If wait_cnt<MAX_WAIT: all enables 0, stall=1, wait_cnt+1.
     - If wait_cnt==MAX_WAIT: forced release. The cycle behaves as normal advance, mem_timeout<=1, wait_cnt<=0.
  3. flush: pc_we=1, all stage_ena=1, valid[0]<=0, valid[k]<=valid[k-1] for k>=1. Flush overrides load_use and imem stall.
  4. load_use: pc_we=0, stage_ena[0]=0, stage_ena[k>=1]=1, valid[1]<=0 (bubble), valid[k>=2]<=valid[k-1], valid[0] held. stall=1.
  5. ~imem_ready: pc_we=0, all stage_ena=1, valid[0]<=0, valid[k]<=valid[k-1]. stall=1.
  6. Normal advance: pc_we=1, all stage_ena=1, valid[0]<=1, valid[k]<=valid[k-1].
- wait_cnt clears to 0 on any enabled cycle that is not mem_wait. It never wraps.
- After reset release, valid fills one register per cycle: NREG cycles to full.
- A dmem_req with stage_valid[NREG-1]==0 is ignored.
- load_use and ~imem_ready together: the load_use rule applies.
- reset==0 mid-stall: state clears at the edge and the pending wait is discarded.
- mem_timeout clears only on reset.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: perf_stall_cycles increments on each cycle with stall==1. perf_retired increments when stage_ena[NREG-1]==1 and stage_valid[NREG-1]==1. Both are 32-bit and wrap modulo 2^32. Both clear on reset.
- Undefined: no counter flops; both ports are tied to 0.

Test Plan:
- Fill: NREG=2, reset 0 then 1 with ena=1 and all ready -> stage_valid 00, 01, 11 on successive cycles; pc_we=1 throughout.
- DMEM wait: full pipe, dmem_req=1, dmem_ready low for 3 cycles then high -> enables 0 and stall=1 for 3 cycles, wait_cnt 1, 2, 3, then advance and wait_cnt=0; mem_timeout stays 0.
- Timeout: MAX_WAIT=3, dmem_ready held 0 -> cycle with wait_cnt==3 gives pc_we=1, mem_timeout=1 sticky, wait_cnt=0.
- Load-use: full pipe, load_use=1 one cycle -> pc_we=0, stage_ena=2'b10, next stage_valid=2'b01; the following cycle resumes normally.
- Flush + imem stall: flush=1 with imem_ready=0 -> pc_we=1, stage_valid[0]<=0; then imem_ready=0 alone -> pc_we=0, bubble enters register 0.
- Perf (macro on): 5 normal cycles + 2 stall cycles from full -> perf_retired=5, perf_stall_cycles=2; macro off -> both read 0.
